ps2_move_decoder: RTL and testbench

Keyboard front end that produces the `move_up/down/right/left` hold levels consumed by the two player drawing blocks. The block receives PS/2 device-to-host frames (scan code set 2), decodes make, break and extended codes, and drives two independent sets of hold flags:
- player 1: W A S D;
- player 2: arrow keys.

It sits between the board PS/2 pins and the `draw_player_*` instances in the top level.

---
 rtl/ps2_pkg.sv | 56 +++++
 rtl/ps2_rx_if.sv | 9 +
 rtl/ps2_rx.sv | 95 +++++++++
 rtl/ps2_move_decoder.sv | 91 +++++++++
 tb/tb_ps2_move_decoder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scan codes, decoder state type and move-flag bundle for the PS/2
// movement front end (scan code set 2).
package ps2_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 65000;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic right;
        logic left;
    } move_t;

    // Apply one make/break code to a player's flags; unknown codes leave them untouched.
    function automatic move_t apply_code(move_t m, logic [7:0] code, logic ext, logic make);
        move_t r;
        r = m;
        if (!ext) begin
            case (code)
                SC_W:    r.up    = make;
                SC_S:    r.down  = make;
                SC_D:    r.right = make;
                SC_A:    r.left  = make;
                default: ;
            endcase
        end else begin
            case (code)
                SC_UP:    r.up    = make;
                SC_DOWN:  r.down  = make;
                SC_RIGHT: r.right = make;
                SC_LEFT:  r.left  = make;
                default:  ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Received-byte stream from the PS/2 frame receiver to the scan-code decoder.
interface ps2_rx_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    modport master (output rx_byte, output rx_valid, output frame_err);
    modport slave  (input  rx_byte, input  rx_valid, input  frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect,
// 11-bit frame shift, odd-parity/framing check and partial-frame timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.master rx
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          fall;
    logic          bit_in;

    assign fall   = clk_prev_q & ~clk_sync_q[1];
    assign bit_in = data_sync_q[1];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        to_cnt_d    = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;

        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                // shift_q[0] is the start bit, [8:1] the data, [9] the parity bit.
                bit_cnt_d = '0;
                if (!shift_q[0] && (^shift_q[9:1]) && bit_in) begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {bit_in, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (to_cnt_q == TO_LIMIT) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            // NOTE: synchronizers reset to the PS/2 idle level so reset release never fakes an edge.
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx.rx_byte   = rx_byte_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.frame_err = frame_err_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front end: decodes make/break/extended scan codes into hold
// flags for player 1 (WASD) and player 2 (arrow keys).
module ps2_move_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic p1_move_up,
    output logic p1_move_down,
    output logic p1_move_right,
    output logic p1_move_left,
    output logic p2_move_up,
    output logic p2_move_down,
    output logic p2_move_right,
    output logic p2_move_left,
    output logic frame_err
);

    ps2_rx_if rx_bus ();

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx       (rx_bus.master)
    );

    dec_state_t state_q, state_d;
    move_t      p1_q, p1_d;
    move_t      p2_q, p2_d;

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        if (rx_bus.rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_bus.rx_byte == SC_EXT)      state_d = EXT;
                    else if (rx_bus.rx_byte == SC_BRK) state_d = BRK;
                    else p1_d = apply_code(p1_q, rx_bus.rx_byte, 1'b0, 1'b1);
                end
                EXT: begin
                    if (rx_bus.rx_byte == SC_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        p2_d    = apply_code(p2_q, rx_bus.rx_byte, 1'b1, 1'b1);
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    p1_d    = apply_code(p1_q, rx_bus.rx_byte, 1'b0, 1'b0);
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    p2_d    = apply_code(p2_q, rx_bus.rx_byte, 1'b1, 1'b0);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
        end
    end

    assign p1_move_up    = p1_q.up;
    assign p1_move_down  = p1_q.down;
    assign p1_move_right = p1_q.right;
    assign p1_move_left  = p1_q.left;
    assign p2_move_up    = p2_q.up;
    assign p2_move_down  = p2_q.down;
    assign p2_move_right = p2_q.right;
    assign p2_move_left  = p2_q.left;
    assign frame_err     = rx_bus.frame_err;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: bit-bangs PS/2 frames and checks flags,
// frame errors, timeout recovery and mid-frame reset.
module tb_ps2_move_decoder;

    localparam int TO_CYC = 100;
    localparam int HALF   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic p1_up, p1_down, p1_right, p1_left;
    logic p2_up, p2_down, p2_right, p2_left;
    logic frame_err;
    logic [7:0] flags;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int rx_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    always #5 clk = ~clk;

    ps2_move_decoder #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .p1_move_up    (p1_up),
        .p1_move_down  (p1_down),
        .p1_move_right (p1_right),
        .p1_move_left  (p1_left),
        .p2_move_up    (p2_up),
        .p2_move_down  (p2_down),
        .p2_move_right (p2_right),
        .p2_move_left  (p2_left),
        .frame_err     (frame_err)
    );

    // Flag order: p1 up/down/right/left, then p2 up/down/right/left.
    assign flags = {p1_up, p1_down, p1_right, p1_left, p2_up, p2_down, p2_right, p2_left};

    always @(posedge clk) begin
        if (frame_err) err_pulses <= err_pulses + 1;
        if (dut.rx_bus.rx_valid) begin
            rx_cnt    <= rx_cnt + 1;
            last_byte <= dut.rx_bus.rx_byte;
        end
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        wait_clks(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame_of(b), 11);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int e0, r0;
    logic [10:0] bad;

    initial begin
        wait_clks(5);
        check("reset_flags", 32'(flags), 32'h00);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        wait_clks(5);

        r0 = rx_cnt;
        send_byte(8'h1D);
        check("w_make_rx", 32'(rx_cnt - r0), 32'd1);
        check("w_make_byte", 32'(last_byte), 32'h1D);
        check("w_make", 32'(flags), 32'h80);
        send_byte(8'hF0); send_byte(8'h1D);
        check("w_break", 32'(flags), 32'h00);

        send_byte(8'hE0); send_byte(8'h75);
        check("up_make", 32'(flags), 32'h08);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("up_break", 32'(flags), 32'h00);
        send_byte(8'h75);
        check("plain_75_ignored", 32'(flags), 32'h00);

        send_byte(8'h1C);
        check("a_make", 32'(flags), 32'h10);
        send_byte(8'h23);
        check("d_make", 32'(flags), 32'h30);
        send_byte(8'hE0); send_byte(8'h6B);
        check("three_held", 32'(flags), 32'h31);
        send_byte(8'hF0); send_byte(8'h23);
        check("d_break_only", 32'(flags), 32'h11);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check("all_clear", 32'(flags), 32'h00);

        e0 = err_pulses; r0 = rx_cnt;
        bad = frame_of(8'h1D);
        bad[9] = ~bad[9];
        send_bits(bad, 11);
        check("parity_err_pulse", 32'(err_pulses - e0), 32'd1);
        check("parity_no_byte", 32'(rx_cnt - r0), 32'd0);
        check("parity_flags", 32'(flags), 32'h00);
        bad = frame_of(8'h1D);
        bad[10] = 1'b0;
        send_bits(bad, 11);
        check("stop_err_pulse", 32'(err_pulses - e0), 32'd2);
        check("stop_flags", 32'(flags), 32'h00);

        e0 = err_pulses; r0 = rx_cnt;
        send_bits(frame_of(8'h1B), 5);
        wait_clks(TO_CYC + 10);
        send_byte(8'h1B);
        check("timeout_rx_cnt", 32'(rx_cnt - r0), 32'd1);
        check("timeout_byte", 32'(last_byte), 32'h1B);
        check("timeout_flags", 32'(flags), 32'h40);
        check("timeout_no_err", 32'(err_pulses - e0), 32'd0);

        send_byte(8'h1B);
        check("typematic_hold", 32'(flags), 32'h40);

        send_byte(8'hE0); send_byte(8'h74);
        check("right_make", 32'(flags), 32'h42);
        send_byte(8'hE0); send_byte(8'hF0);
        send_bits(frame_of(8'h74), 4);
        check("pre_reset_flags", 32'(flags), 32'h42);
        rst = 1'b1;
        wait_clks(3);
        check("mid_reset_flags", 32'(flags), 32'h00);
        rst = 1'b0;
        wait_clks(5);
        send_byte(8'h1D);
        check("post_reset_w", 32'(flags), 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
